al_excpt_commit: RTL and testbench
==================================

AL_EXCPT_COMMIT -- requirements
Module: al_excpt_commit

Interface
REQ-001 Parameter COMMIT_WIDTH, default 4, gives the number of commit lanes, allowed range 1..4.
REQ-002 Parameter EXCPT_W, default 8, gives the width of the per-entry exception word; a value of 0 means no exception.
REQ-003 Parameter AL_INDEX, default 7, gives the active-list index width.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port headValid_i, input, COMMIT_WIDTH bits: lane i set means active-list entry head+i has completed and may retire.
REQ-007 Port excptData_i, input, COMMIT_WIDTH x EXCPT_W bits: exception word read for entry head+i.
REQ-008 Port headPtr_i, input, AL_INDEX bits: active-list head index.
REQ-009 Port sbEmpty_i, input, 1 bit: the committed store buffer is drained.
REQ-010 Port redirectAck_i, input, 1 bit: fetch accepted the trap redirect.
REQ-011 Port commitMask_o, output, COMMIT_WIDTH bits: lanes retiring this cycle.
REQ-012 Port flush_o, output, 1 bit: one-cycle pipeline flush pulse.
REQ-013 Port excptValid_o, output, 1 bit: one-cycle trap-taken pulse, coincident with flush_o.
REQ-014 Port excptCause_o, output, EXCPT_W bits: captured exception word.
REQ-015 Port excptAlIdx_o, output, AL_INDEX bits: active-list index of the trapping instruction.
REQ-016 Port busy_o, output, 1 bit: the FSM is not in IDLE.

Function
REQ-017 The block SHALL implement FSM states IDLE, DRAIN, FLUSH and REDIRECT.
REQ-018 In IDLE, commitMask_o SHALL be the contiguous prefix of headValid_i that ends before the first invalid lane or the first lane with a non-zero exception word, whichever comes first (combinational, zero latency).
REQ-019 A lane with a non-zero exception word at lane k>0 SHALL NOT retire; lanes 0..k-1 SHALL retire, and the trap is taken only once the instruction reaches lane 0.
REQ-020 In IDLE, if headValid_i[0] is set and excptData_i[0] is non-zero, commitMask_o SHALL be 0, excptCause_o SHALL capture excptData_i[0], excptAlIdx_o SHALL capture headPtr_i, and the next state SHALL be DRAIN.
REQ-021 In DRAIN, commitMask_o SHALL be 0; the FSM SHALL move to FLUSH in the cycle after sbEmpty_i is sampled at 1; if sbEmpty_i is already 1 on entry, DRAIN SHALL last exactly one cycle.
REQ-022 In FLUSH, flush_o and excptValid_o SHALL be 1 for exactly one cycle, and the next state SHALL be REDIRECT.
REQ-023 In REDIRECT, the FSM SHALL hold until redirectAck_i is 1, then return to IDLE; an ack that arrives in any other state SHALL be ignored.
REQ-024 excptCause_o and excptAlIdx_o SHALL hold their values until the next capture.
REQ-025 Lanes beyond the first invalid lane SHALL NOT retire, even if they are valid.
REQ-026 Outside IDLE, headValid_i and excptData_i SHALL be ignored.
REQ-027 Active-list index wrap is the producer's responsibility; headPtr_i SHALL be captured verbatim.

Reset
REQ-028 On reset assertion (asynchronous), the state SHALL become IDLE, and flush_o, excptValid_o, excptCause_o, excptAlIdx_o and busy_o SHALL become 0.
REQ-029 A reset in any non-IDLE state SHALL abort the trap without emitting flush_o.
REQ-030 commitMask_o SHALL follow REQ-018 from the first cycle after reset deasserts.

Configuration
REQ-031 With macro AL_EXCPT_COUNT_EN defined, the block SHALL add an output excptCount_o (32 bits) that increments by 1 on every FLUSH cycle, saturates at all-ones, and resets to 0.
REQ-032 Without AL_EXCPT_COUNT_EN, the excptCount_o port and its counter SHALL NOT exist.

Structure
REQ-033 The FSM state enum and the exception-word "none" constant SHALL live in the shared core package.
REQ-034 A sub-module excpt_prio_enc SHALL compute the commit prefix mask and the first-excepting-lane index from headValid_i and excptData_i.

Verification
REQ-035 headValid=4'b1111 with all exception words 0 -> commitMask_o=4'b1111, busy_o=0.
REQ-036 headValid=4'b1111 with lane 2 word 8'h05 -> commitMask_o=4'b0011; next cycle with head advanced (lane 0 word 8'h05, headPtr=7'd10) -> mask 0, DRAIN, excptCause_o=8'h05, excptAlIdx_o=7'd10.
REQ-037 In DRAIN, sbEmpty_i held at 0 for 5 cycles then set to 1 -> one cycle later flush_o=1 and excptValid_o=1 for exactly one cycle.
REQ-038 In REDIRECT, redirectAck_i is held 0 for 3 cycles then pulsed 1 -> busy_o stays 1 until the cycle after the ack, then returns to 0.
REQ-039 Reset is asserted mid-DRAIN -> IDLE, with no flush_o pulse at any time.
REQ-040 With AL_EXCPT_COUNT_EN defined, three complete traps -> excptCount_o=3.

Source files
------------

// File: rtl/al_excpt_commit_pkg.sv
// rtl/al_excpt_commit_pkg.sv - shared types and constants for the exception commit block
package al_excpt_commit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } commit_state_e;

    // An exception word equal to this value means the entry did not fault.
    localparam int unsigned EXCPT_NONE = 0;

endpackage

// File: rtl/al_excpt_commit_prio_enc.sv
// rtl/al_excpt_commit_prio_enc.sv - retire-prefix mask and first-excepting-lane finder
module excpt_prio_enc
    import al_excpt_commit_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int EXCPT_W      = 8,
    parameter int LANE_W       = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
    input  logic [COMMIT_WIDTH-1:0]         head_valid,
    input  logic [COMMIT_WIDTH*EXCPT_W-1:0] excpt_data,
    output logic [COMMIT_WIDTH-1:0]         commit_mask,
    output logic [LANE_W-1:0]               excpt_lane,
    output logic                            excpt_found
);

    logic stop;

    // The scan stops at the first invalid lane or the first valid lane that faulted;
    // only a fault reached before any gap is reported.
    always_comb begin
        commit_mask = '0;
        excpt_lane  = '0;
        excpt_found = 1'b0;
        stop        = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (!stop) begin
                if (!head_valid[i]) begin
                    stop = 1'b1;
                end else if (excpt_data[i*EXCPT_W +: EXCPT_W] != EXCPT_W'(EXCPT_NONE)) begin
                    stop        = 1'b1;
                    excpt_found = 1'b1;
                    excpt_lane  = LANE_W'(i);
                end else begin
                    commit_mask[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/al_excpt_commit.sv
// rtl/al_excpt_commit.sv - in-order commit with precise trap sequencing (AL_EXCPT_COUNT_EN adds a trap counter)
module al_excpt_commit
    import al_excpt_commit_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int EXCPT_W      = 8,
    parameter int AL_INDEX     = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [COMMIT_WIDTH-1:0]         headValid_i,
    input  logic [COMMIT_WIDTH*EXCPT_W-1:0] excptData_i,
    input  logic [AL_INDEX-1:0]             headPtr_i,
    input  logic                            sbEmpty_i,
    input  logic                            redirectAck_i,
    output logic [COMMIT_WIDTH-1:0]         commitMask_o,
    output logic                            flush_o,
    output logic                            excptValid_o,
    output logic [EXCPT_W-1:0]              excptCause_o,
    output logic [AL_INDEX-1:0]             excptAlIdx_o,
    output logic                            busy_o
`ifdef AL_EXCPT_COUNT_EN
    ,
    output logic [31:0]                     excptCount_o
`endif
);

    localparam int LANE_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    commit_state_e            state_q, state_d;
    logic [EXCPT_W-1:0]       cause_q, cause_d;
    logic [AL_INDEX-1:0]      alidx_q, alidx_d;
    logic [COMMIT_WIDTH-1:0]  prefix_mask;
    logic [LANE_W-1:0]        excpt_lane;
    logic                     excpt_found;
    logic                     trap_at_head;

    excpt_prio_enc #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .EXCPT_W      (EXCPT_W),
        .LANE_W       (LANE_W)
    ) u_prio_enc (
        .head_valid  (headValid_i),
        .excpt_data  (excptData_i),
        .commit_mask (prefix_mask),
        .excpt_lane  (excpt_lane),
        .excpt_found (excpt_found)
    );

    // A fault further up the window only blocks retirement; the trap waits until it is at the head.
    assign trap_at_head = excpt_found && (excpt_lane == '0);

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        alidx_d      = alidx_q;
        commitMask_o = '0;
        flush_o      = 1'b0;
        excptValid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                commitMask_o = prefix_mask;
                if (trap_at_head) begin
                    cause_d = excptData_i[EXCPT_W-1:0];
                    alidx_d = headPtr_i;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sbEmpty_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_o      = 1'b1;
                excptValid_o = 1'b1;
                state_d      = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirectAck_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
            alidx_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            alidx_q <= alidx_d;
        end
    end

    assign excptCause_o = cause_q;
    assign excptAlIdx_o = alidx_q;
    assign busy_o       = (state_q != ST_IDLE);

`ifdef AL_EXCPT_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if ((state_q == ST_FLUSH) && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign excptCount_o = count_q;
`endif

endmodule

// File: tb/tb_al_excpt_commit.sv
// tb/tb_al_excpt_commit.sv - self-checking bench for al_excpt_commit (honours AL_EXCPT_COUNT_EN)
module tb_al_excpt_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  hv;
    logic [31:0] ex;
    logic [6:0]  hp;
    logic        sb;
    logic        ack;
    logic [3:0]  commit_mask;
    logic        flush;
    logic        excpt_valid;
    logic [7:0]  cause;
    logic [6:0]  alidx;
    logic        busy;
`ifdef AL_EXCPT_COUNT_EN
    logic [31:0] count;
`endif

    al_excpt_commit #(
        .COMMIT_WIDTH (4),
        .EXCPT_W      (8),
        .AL_INDEX     (7)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .headValid_i   (hv),
        .excptData_i   (ex),
        .headPtr_i     (hp),
        .sbEmpty_i     (sb),
        .redirectAck_i (ack),
        .commitMask_o  (commit_mask),
        .flush_o       (flush),
        .excptValid_o  (excpt_valid),
        .excptCause_o  (cause),
        .excptAlIdx_o  (alidx),
        .busy_o        (busy)
`ifdef AL_EXCPT_COUNT_EN
        ,
        .excptCount_o  (count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [3:0]  hv;
        logic [31:0] ex;
        logic [3:0]  mask;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   flush_seen = 0;

    always @(posedge clk) begin
        #1;
        if (flush === 1'b1) flush_seen++;
    end

    task automatic expect_val(input string name, input logic [31:0] v);
        sb_q.push_back('{name, v});
    endtask

    task automatic check_out(input logic [31:0] act);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty actual=%0h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s actual=%0h expected=%0h", e.name, act, e.val);
            end
        end
    endtask

    task automatic run_trap(input logic [7:0] code, input logic [6:0] idx);
        bit done;
        hv = 4'b0001; ex = {24'h0, code}; hp = idx; sb = 1'b1; ack = 1'b0;
        @(negedge clk);
        hv = 4'b0000; ex = '0;
        @(negedge clk);
        @(negedge clk);
        ack = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        ack = 1'b0;
        expect_val("trap_returns_idle", 32'd1);
        check_out({31'd0, done});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b1111, 32'h00000000, 4'b1111};
        vecs[1] = '{4'b0000, 32'h00000000, 4'b0000};
        vecs[2] = '{4'b0001, 32'h00000000, 4'b0001};
        vecs[3] = '{4'b1101, 32'h00000000, 4'b0001};
        vecs[4] = '{4'b0111, 32'h00000000, 4'b0111};
        vecs[5] = '{4'b1111, 32'h01000000, 4'b0111};
        vecs[6] = '{4'b1111, 32'h0000ff00, 4'b0001};
        vecs[7] = '{4'b1011, 32'h00050000, 4'b0011};
        vecs[8] = '{4'b1110, 32'h00000000, 4'b0000};
        vecs[9] = '{4'b1110, 32'h00000007, 4'b0000};

        reset = 1'b1; hv = '0; ex = '0; hp = '0; sb = 1'b0; ack = 1'b0;
        #1;
        expect_val("rst_flush", 0);       check_out({31'd0, flush});
        expect_val("rst_excpt_valid", 0); check_out({31'd0, excpt_valid});
        expect_val("rst_cause", 0);       check_out({24'd0, cause});
        expect_val("rst_alidx", 0);       check_out({25'd0, alidx});
        expect_val("rst_busy", 0);        check_out({31'd0, busy});
`ifdef AL_EXCPT_COUNT_EN
        expect_val("rst_count", 0);       check_out(count);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            hv = vecs[i].hv; ex = vecs[i].ex; hp = 7'(i);
            expect_val($sformatf("vec%0d_mask", i), {28'd0, vecs[i].mask});
            expect_val($sformatf("vec%0d_busy", i), 32'd0);
            #1 check_out({28'd0, commit_mask});
            @(negedge clk);
            check_out({31'd0, busy});
        end

        // Fault at lane 2 retires lanes 0..1, then traps once at the head.
        hv = 4'b1111; ex = 32'h00050000; hp = 7'd9;
        expect_val("l2_fault_mask", 32'h3);
        #1 check_out({28'd0, commit_mask});
        @(negedge clk);
        ex = 32'h00000005; hp = 7'd10;
        expect_val("head_fault_mask", 0);
        #1 check_out({28'd0, commit_mask});
        @(negedge clk);
        hv = 4'b1111; ex = '0;
        expect_val("drain_busy", 1);
        expect_val("drain_cause", 32'h05);
        expect_val("drain_alidx", 32'd10);
        expect_val("drain_mask_ignored", 0);
        #1 check_out({31'd0, busy});
        check_out({24'd0, cause});
        check_out({25'd0, alidx});
        check_out({28'd0, commit_mask});

        for (int k = 0; k < 5; k++) begin
            ack = (k == 0);
            expect_val($sformatf("drain_hold%0d_flush", k), 0);
            expect_val($sformatf("drain_hold%0d_busy", k), 1);
            #1 check_out({31'd0, flush});
            check_out({31'd0, busy});
            @(negedge clk);
        end
        ack = 1'b0; sb = 1'b1;
        expect_val("drain_last_flush", 0);
        check_out({31'd0, flush});
        @(negedge clk);
        expect_val("flush_pulse", 1);
        expect_val("excpt_valid_pulse", 1);
        check_out({31'd0, flush});
        check_out({31'd0, excpt_valid});
        @(negedge clk);
        expect_val("redirect_flush_low", 0);
        expect_val("redirect_valid_low", 0);
        check_out({31'd0, flush});
        check_out({31'd0, excpt_valid});
        for (int k = 0; k < 3; k++) begin
            expect_val($sformatf("redirect_wait%0d_busy", k), 1);
            check_out({31'd0, busy});
            @(negedge clk);
        end
        ack = 1'b1;
        expect_val("redirect_ack_cycle_busy", 1);
        check_out({31'd0, busy});
        @(negedge clk);
        ack = 1'b0;
        expect_val("after_ack_busy", 0);
        expect_val("cause_held", 32'h05);
        expect_val("alidx_held", 32'd10);
        expect_val("one_flush_seen", 1);
        check_out({31'd0, busy});
        check_out({24'd0, cause});
        check_out({25'd0, alidx});
        check_out(flush_seen);

        // Store buffer already empty: DRAIN lasts a single cycle.
        sb = 1'b1; hv = 4'b0001; ex = 32'h000000aa; hp = 7'd127;
        @(negedge clk);
        hv = '0; ex = '0;
        expect_val("fast_drain_busy", 1);
        expect_val("fast_drain_flush", 0);
        expect_val("fast_alidx", 32'd127);
        expect_val("fast_cause", 32'haa);
        check_out({31'd0, busy});
        check_out({31'd0, flush});
        check_out({25'd0, alidx});
        check_out({24'd0, cause});
        @(negedge clk);
        expect_val("fast_flush", 1);
        check_out({31'd0, flush});
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        expect_val("fast_idle", 0);
        expect_val("two_flush_seen", 2);
        check_out({31'd0, busy});
        check_out(flush_seen);

        // Reset mid-DRAIN aborts the trap with no flush.
        sb = 1'b0; hv = 4'b0001; ex = 32'h00000033; hp = 7'd5;
        @(negedge clk);
        hv = '0; ex = '0;
        @(negedge clk);
        expect_val("pre_abort_busy", 1);
        check_out({31'd0, busy});
        #2 reset = 1'b1;
        expect_val("abort_busy", 0);
        expect_val("abort_cause", 0);
        expect_val("abort_alidx", 0);
        expect_val("abort_flush", 0);
        #1 check_out({31'd0, busy});
        check_out({24'd0, cause});
        check_out({25'd0, alidx});
        check_out({31'd0, flush});
        @(negedge clk);
        reset = 1'b0; hv = 4'b0111; ex = '0; sb = 1'b1;
        expect_val("post_reset_mask", 32'h7);
        #1 check_out({28'd0, commit_mask});
        repeat (3) @(negedge clk);
        expect_val("post_reset_busy", 0);
        expect_val("no_abort_flush", 2);
        check_out({31'd0, busy});
        check_out(flush_seen);

`ifdef AL_EXCPT_COUNT_EN
        run_trap(8'h11, 7'd1);
        run_trap(8'h22, 7'd2);
        run_trap(8'h33, 7'd3);
        expect_val("count_three", 3);
        check_out(count);
`else
        run_trap(8'h11, 7'd1);
        expect_val("extra_trap_cause", 32'h11);
        check_out({24'd0, cause});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
